// File: rtl/im_loader_if.sv
// Byte-stream port of the instruction-store loader.
//
// Handshake: the source drives byte_valid/byte_data, the loader drives
// byte_ready. A byte transfers at a rising edge exactly when byte_valid and
// byte_ready are both 1. The source keeps byte_data stable while byte_valid is
// high and not yet accepted; byte_ready never depends on byte_valid.
interface im_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );
endinterface

// File: rtl/im_loader.sv
// Boot loader and writable instruction store for the single-cycle CPU.
// A length-prefixed image (16-bit big-endian word count, then big-endian
// 32-bit words) is written from word 0 upward; the CPU is held meanwhile.
// The fetch port is the same combinational read the datapath uses.
module im_loader #(
    parameter int          DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0000_3000
) (
    input  logic              i_clk,
    input  logic              i_reset,        // synchronous, active low
    input  logic              i_load_start,
    im_loader_if.slave        bus,
    output logic              o_cpu_hold,
    output logic              o_load_done,
    output logic              o_load_err,
    output logic [10:0]       o_words_loaded,
    input  logic [31:0]       i_addr_im,
    output logic [31:0]       o_instr,
    output logic [2:0]        o_dbg_state
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [15:0]   r_len;
    logic [23:0]   r_asm;
    logic [1:0]    r_byte_cnt;
    logic [AW-1:0] r_wr_idx;
    logic [10:0]   r_words_loaded;
    logic          r_load_err;
    logic [31:0]   r_ram [DEPTH];

    logic          w_ready;
    logic          w_hold;
    logic          w_done;
    logic          w_xfer;
    logic          w_word_wr;
    logic          w_len_ovf;
    logic [15:0]   w_len_full;
    logic [10:0]   w_words_next;
    logic [AW-1:0] w_fetch_idx;

    // Full length as seen on the LEN_LO byte; next word count after a write.
    assign w_len_full   = {r_len[15:8], bus.byte_data};
    assign w_words_next = r_words_loaded + 11'd1;
    assign w_xfer       = bus.byte_valid & w_ready;

    // Next-state and Moore outputs; every signal defaulted first.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_hold       = 1'b1;
        w_done       = 1'b0;
        w_word_wr    = 1'b0;
        w_len_ovf    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_hold = 1'b0;
                if (i_load_start) w_next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                w_ready = 1'b1;
                if (bus.byte_valid) w_next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                w_ready = 1'b1;
                if (bus.byte_valid) begin
                    if (w_len_full == 16'd0) begin
                        w_next_state = S_DONE;
                    end else if (w_len_full > 16'(DEPTH)) begin
                        w_len_ovf    = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                w_ready = 1'b1;
                if (bus.byte_valid && r_byte_cnt == 2'd3) begin
                    w_word_wr = 1'b1;
                    if ({5'd0, w_words_next} == r_len) w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register; reset abandons any load in progress.
    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Length latch, word assembly, counters and the sticky error flag.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_len          <= 16'd0;
            r_asm          <= 24'd0;
            r_byte_cnt     <= 2'd0;
            r_wr_idx       <= '0;
            r_words_loaded <= 11'd0;
            r_load_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load_start) begin
                        r_byte_cnt     <= 2'd0;
                        r_wr_idx       <= '0;
                        r_words_loaded <= 11'd0;
                        r_load_err     <= 1'b0;
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) r_len[15:8] <= bus.byte_data;
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len_full;
                        if (w_len_ovf) r_load_err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_asm      <= {r_asm[15:0], bus.byte_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_word_wr) begin
                            r_wr_idx       <= r_wr_idx + AW'(1);
                            r_words_loaded <= w_words_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Instruction RAM write; contents survive reset, no write while in reset.
    always_ff @(posedge i_clk) begin
        if (i_reset && w_word_wr) r_ram[r_wr_idx] <= {r_asm, bus.byte_data};
    end

    // Fetch index: word offset from BASE, wrapping modulo DEPTH.
    assign w_fetch_idx = AW'((i_addr_im - BASE) >> 2);

    assign o_instr        = r_ram[w_fetch_idx];
    assign bus.byte_ready = w_ready;
    assign o_cpu_hold     = w_hold;
    assign o_load_done    = w_done;
    assign o_load_err     = r_load_err;
    assign o_words_loaded = r_words_loaded;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_im_loader.sv
// Directed + randomized bench for im_loader with a word-level image model.
module tb_im_loader;
    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_load_start = 1'b0;
    logic [31:0] i_addr_im = BASE;
    logic        o_cpu_hold, o_load_done, o_load_err;
    logic [10:0] o_words_loaded;
    logic [31:0] o_instr;
    logic [2:0]  o_dbg_state;

    im_loader_if bus();

    im_loader #(.DEPTH(1024), .BASE(BASE)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_load_start   (i_load_start),
        .bus            (bus),
        .o_cpu_hold     (o_cpu_hold),
        .o_load_done    (o_load_done),
        .o_load_err     (o_load_err),
        .o_words_loaded (o_words_loaded),
        .i_addr_im      (i_addr_im),
        .o_instr        (o_instr),
        .o_dbg_state    (o_dbg_state)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  img_q[$];
    logic [31:0] mem_m [1024];
    bit          wr_m  [1024];
    int          exp_words;
    bit          exp_err;
    int          done_cyc, idle_cyc, n_acc;
    logic        err_c1;
    bit          watch, pend;
    int          watch_hits;
    logic [31:0] watch_old, watch_new;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        i_addr_im = addr;
        #1;
        check(tag, o_instr, exp);
    endtask

    // Builds an image of n words: 16-bit big-endian count, then random bytes.
    task automatic make_img(input int n);
        img_q = {};
        img_q.push_back(8'(n >> 8));
        img_q.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) img_q.push_back(8'($urandom));
    endtask

    // Reference: apply the first n_bytes accepted bytes of img_q to memory.
    function automatic void model_load(input int n_bytes);
        int len;
        exp_err   = 0;
        exp_words = 0;
        if (n_bytes < 2) return;
        len = {img_q[0], img_q[1]};
        if (len > 1024) begin
            exp_err = 1;
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (2 + 4 * i + 3 < n_bytes) begin
                mem_m[i]  = {img_q[2+4*i], img_q[3+4*i], img_q[4+4*i], img_q[5+4*i]};
                wr_m[i]   = 1;
                exp_words = i + 1;
            end
        end
    endfunction

    // Pulses load_start, streams img_q (mode 0 continuous, 1 alternating,
    // 2 random valid plus stray load_start), and records the cycle (counted
    // from the acceptance edge) of load_done and of the return to IDLE.
    task automatic run_load(input int mode, input int abort_at);
        bit v, xfer;
        n_acc = 0; done_cyc = -1; idle_cyc = -1; pend = 0; err_c1 = 1'b1;
        @(negedge clk);
        i_load_start = 1'b1;
        for (int t = 1; t <= 6000; t++) begin
            @(negedge clk);
            i_load_start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (t == 1) err_c1 = o_load_err;
            if (pend) begin
                check("fetch_after_wr", o_instr, watch_new);
                pend = 0;
            end
            if (o_load_done && done_cyc < 0) begin
                done_cyc = t;
                check("ready_in_done", 32'(bus.byte_ready), 32'd0);
            end
            if (!o_cpu_hold) begin
                idle_cyc = t;
                break;
            end
            if (abort_at >= 0 && n_acc == abort_at) begin
                bus.byte_valid = 1'b0;
                i_reset = 1'b0;
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (t % 2 == 1);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (n_acc >= img_q.size()) v = 1'b0;
            bus.byte_valid = v;
            bus.byte_data  = v ? img_q[n_acc] : 8'($urandom);
            xfer = v && bus.byte_ready;
            if (watch && xfer && n_acc == 5) begin
                check("fetch_before_wr", o_instr, watch_old);
                pend = 1;
                watch_hits++;
            end
            if (xfer) n_acc++;
        end
        i_load_start   = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    task automatic check_words(input string tag);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = $urandom_range(0, 1023);
            if (wr_m[idx])
                fetch(tag, BASE + 32'(idx * 4) + 32'($urandom_range(0, 3) * 4096)
                      + 32'($urandom_range(0, 3)), mem_m[idx]);
        end
    endtask

    task automatic check_spec_words(input string tag);
        fetch({tag, "_w0"}, 32'h0000_3000, 32'h3C01_0000);
        fetch({tag, "_w1"}, 32'h0000_3004, 32'h3421_0001);
        fetch({tag, "_w2"}, 32'h0000_3008, 32'hAC01_0000);
    endtask

    task automatic load_spec_img();
        logic [7:0] spec_img [14];
        spec_img = '{8'h00, 8'h03, 8'h3C, 8'h01, 8'h00, 8'h00, 8'h34,
                     8'h21, 8'h00, 8'h01, 8'hAC, 8'h01, 8'h00, 8'h00};
        img_q = {};
        for (int i = 0; i < 14; i++) img_q.push_back(spec_img[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        watch = 0; watch_hits = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hold",  32'(o_cpu_hold), 32'd0);
        check("rst_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_done",  32'(o_load_done), 32'd0);
        check("rst_err",   32'(o_load_err), 32'd0);
        check("rst_words", 32'(o_words_loaded), 32'd0);
        i_reset = 1'b1;

        // Three-word load, continuous stream
        load_spec_img();
        run_load(0, -1);
        model_load(n_acc);
        check("t1_done_cyc", 32'(done_cyc), 32'd15);
        check("t1_idle_cyc", 32'(idle_cyc), 32'd16);
        check("t1_words", 32'(o_words_loaded), 32'd3);
        check("t1_err", 32'(o_load_err), 32'd0);
        check("t1_ready_idle", 32'(bus.byte_ready), 32'd0);
        check_spec_words("t1");

        // Random image with random stalls, then spec image with alternating valid
        make_img(5);
        run_load(2, -1);
        model_load(n_acc);
        check("t2a_words", 32'(o_words_loaded), 32'(exp_words));
        check("t2a_hold_drop", 32'(idle_cyc), 32'(done_cyc + 1));
        check_words("t2a_fetch");
        load_spec_img();
        run_load(1, -1);
        model_load(n_acc);
        check("t2_done_seen", 32'(done_cyc > 0), 32'd1);
        check("t2_hold_drop", 32'(idle_cyc), 32'(done_cyc + 1));
        check("t2_words", 32'(o_words_loaded), 32'd3);
        check_spec_words("t2");

        // Zero length
        img_q = {8'h00, 8'h00};
        run_load(0, -1);
        check("t3_done_cyc", 32'(done_cyc), 32'd3);
        check("t3_idle_cyc", 32'(idle_cyc), 32'd4);
        check("t3_words", 32'(o_words_loaded), 32'd0);
        check_spec_words("t3");

        // Overflow: length 1025
        img_q = {8'h04, 8'h01};
        run_load(0, -1);
        model_load(n_acc);
        check("t4_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
        check("t4_idle_cyc", 32'(idle_cyc), 32'd3);
        check("t4_err", 32'(o_load_err), 32'(exp_err));
        check("t4_ready", 32'(bus.byte_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("t4_err_sticky", 32'(o_load_err), 32'd1);
        make_img(1);
        run_load(0, -1);
        model_load(n_acc);
        check("t4_err_cleared", 32'(err_c1), 32'd0);
        check("t4_next_done", 32'(done_cyc), 32'd7);
        check("t4_next_words", 32'(o_words_loaded), 32'd1);
        check_words("t4_fetch");

        // Full-depth load (largest legal length)
        make_img(1024);
        run_load(0, -1);
        model_load(n_acc);
        check("t5_done_cyc", 32'(done_cyc), 32'd4099);
        check("t5_words", 32'(o_words_loaded), 32'd1024);
        check("t5_err", 32'(o_load_err), 32'd0);
        check_words("t5_fetch");

        // Reset after 6 data bytes of a 2-word load
        make_img(2);
        run_load(0, 8);
        model_load(n_acc);
        @(negedge clk);
        check("t6_hold",  32'(o_cpu_hold), 32'd0);
        check("t6_ready", 32'(bus.byte_ready), 32'd0);
        check("t6_done",  32'(o_load_done), 32'd0);
        check("t6_err",   32'(o_load_err), 32'd0);
        check("t6_words", 32'(o_words_loaded), 32'd0);
        i_load_start = 1'b1;
        @(negedge clk);
        check("t6_start_in_rst", 32'(o_cpu_hold), 32'd0);
        i_load_start = 1'b0;
        i_reset = 1'b1;
        @(negedge clk);
        check("t6_idle_after", 32'(o_cpu_hold), 32'd0);
        fetch("t6_w0_kept", 32'h0000_3000, mem_m[0]);
        fetch("t6_w1_old", 32'h0000_3004, mem_m[1]);

        // Write timing observed through the aliased address 0x4000
        make_img(2);
        watch_old = mem_m[0];
        watch_new = {img_q[2], img_q[3], img_q[4], img_q[5]};
        i_addr_im = 32'h0000_4000;
        watch = 1;
        run_load(0, -1);
        watch = 0;
        model_load(n_acc);
        check("t7_watch_hits", 32'(watch_hits), 32'd1);
        check("t7_words", 32'(o_words_loaded), 32'd2);
        fetch("t7_alias_4000", 32'h0000_4000, mem_m[0]);
        fetch("t7_base_3000", 32'h0000_3000, mem_m[0]);

        // Random loads
        for (int r = 0; r < 4; r++) begin
            int n, m;
            n = $urandom_range(1, 8);
            m = $urandom_range(0, 2);
            make_img(n);
            run_load(m, -1);
            model_load(n_acc);
            check("rnd_words", 32'(o_words_loaded), 32'(exp_words));
            check("rnd_err", 32'(o_load_err), 32'd0);
            check("rnd_hold_drop", 32'(idle_cyc), 32'(done_cyc + 1));
            if (m == 0) check("rnd_done_cyc", 32'(done_cyc), 32'(2 + 4 * n + 1));
            check_words("rnd_fetch");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Byte-stream boot loader and writable instruction store for the single-cycle CPU.
- Receives a length-prefixed program image over a valid/ready byte interface, assembles big-endian 32-bit words and writes them sequentially from word 0, which maps to address 0x00003000.
- Exposes the same combinational fetch port the CPU datapath uses (byte address in, instruction out).
- Holds the CPU via `cpu_hold` while a load is in progress.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words (index width 10).
- BASE, 32'h00003000, byte address of word 0.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-low reset (0 = reset).
- `load_start`  input  1  pulse in IDLE begins a load; ignored in other states.
- `byte_valid`  input  1  source has a byte on `byte_data`.
- `byte_data`  input  8  stream byte.
- `byte_ready`  output  1  loader accepts a byte this cycle; transfer = `byte_valid` & `byte_ready` at the edge.
- `cpu_hold`  output  1  high while a load is in progress; the CPU must not advance its PC.
- `load_done`  output  1  one-cycle pulse when a load completes successfully.
- `load_err`  output  1  sticky; set on a length-overflow error, cleared by the next accepted `load_start` or by reset.
- `words_loaded`  output  11  words written by the current/last load.
- `addr_im`  input  32  CPU fetch byte address.
- `instr`  output  32  `ram[(addr_im - BASE)[11:2]]`, combinational.

Behaviour:
- Reset (`reset`=0 at an edge):
  - State returns to IDLE.
  - `byte_ready`, `cpu_hold`, `load_done`, `load_err` = 0; `words_loaded` = 0.
  - Word counter and byte counter are cleared.
  - RAM contents are not cleared.
  - Reset mid-load abandons the load; words already written remain.
- States: IDLE, LEN_HI, LEN_LO, DATA, DONE.
  - IDLE: `byte_ready`=0, `cpu_hold`=0. `load_start`=1 → LEN_HI; clear `load_err`, `words_loaded`, and the byte and word counters.
  - LEN_HI: `byte_ready`=1. On transfer, latch `len[15:8]` → LEN_LO.
  - LEN_LO: `byte_ready`=1. On transfer, latch `len[7:0]`; the full length is {`len[15:8]`, `byte_data`}.
    - Length 0 → DONE.
    - Length > DEPTH → set `load_err`, → IDLE; no `load_done`.
    - Otherwise → DATA.
  - DATA: `byte_ready`=1. Each transfer shifts `byte_data` into a 24-bit assembly register; the first byte of a word is the MSB.
    - On the 4th byte of a word, at that same edge: `ram[wr_idx]` <= {asm[23:0], `byte_data`}; `wr_idx` and `words_loaded` increment; the byte counter wraps to 0.
    - When `words_loaded` reaches the length → DONE.
  - DONE: `byte_ready`=0, `load_done`=1 for exactly this one cycle → IDLE.
- `cpu_hold` = 1 in LEN_HI, LEN_LO, DATA, DONE; 0 in IDLE.
- Stalls: cycles with `byte_valid`=0 change nothing. There is no timeout.
- `load_start` outside IDLE is ignored.
- Fetch port:
  - Purely combinational; subtraction is 32-bit modulo; index = bits [11:2] of the difference. Addresses outside the window alias modulo DEPTH.
  - A fetch of the word being written shows the old value until the writing edge, the new value after it.
  - Unwritten words read as X in simulation; this is not checked.
- Throughput: one byte per cycle sustained. A load of N words takes 2 + 4N accepted transfers plus one DONE cycle.

Test Plan:
- Reset → load 3 words. Release `reset`, pulse `load_start`, stream 00 03 3C 01 00 00 34 21 00 01 AC 01 00 00 with `byte_valid`=1 continuously.
  - Required: `load_done` pulses exactly 15 cycles after `load_start` is accepted; `words_loaded`=3.
  - Required fetches: `addr_im`=0x3000 → 3C010000, 0x3004 → 34210001, 0x3008 → AC010000.
- Backpressure/stall. Same image with `byte_valid` toggling 1,0,1,0.
  - Required: identical RAM contents; `cpu_hold` stays 1 throughout and drops the cycle after `load_done`.
  - Required: `byte_ready`=0 in IDLE and DONE.
- Zero length. Stream 00 00.
  - Required: `load_done` pulses; `words_loaded`=0; RAM unchanged; total 3 cycles from start to IDLE.
- Overflow. Stream 04 01 (length 1025).
  - Required: `load_err`=1, no `load_done`, IDLE, `byte_ready`=0.
  - Required: the next `load_start` clears `load_err`.
- Reset mid-load. Assert `reset`=0 after 6 data bytes of a 2-word load.
  - Required next cycle: IDLE, all outputs 0; word 0 retains its written value; `load_start` ignored while `reset`=0.
- Fetch aliasing and write timing. Fetch 0x3000 while its first word is being written.
  - Required: old value before the 4th-byte edge, new value after.
  - Required: fetch of 0x4000 returns the same word as 0x3000.
